fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer on the consumer side of the program counter. Takes the PC's current address, runs a request/acknowledge transaction with instruction memory, and returns `stall`/`confirm` to the PC so it advances exactly once per accepted instruction. Delivers each fetched word to decode with a one-cycle `instr_valid` strobe. Handles halt, flush of an in-flight fetch, and memory timeout.

## Interface
- `ADDR_W`, 32, address width; matches PC width.
- `DATA_W`, 32, instruction word width.
- `TIMEOUT`, 15, maximum cycles spent waiting for `mem_ack` before error; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low. 0 at a rising edge resets the block.
- `pc`  in  ADDR_W  current PC value (PC `pc_out`).
- `halt`  in  1  same halt that freezes the PC.
- `flush`  in  1  discard any in-flight fetch (redirect or exception).
- `stall`  out  ADDR_W-independent 1  to PC `stall`; PC holds unless `confirm`.
- `confirm`  out  1  to PC `confirm`; one-cycle pulse, PC loads next address.
- `mem_req`  out  1  instruction-memory request, held until acknowledged.
- `mem_addr`  out  ADDR_W  request address, stable while `mem_req`=1.
- `mem_ack`  in  1  memory response valid; sampled only while `mem_req`=1.
- `mem_rdata`  in  DATA_W  instruction data, valid with `mem_ack`.
- `instr`  out  DATA_W  last accepted instruction, held between fetches.
- `instr_valid`  out  1  one-cycle strobe, `instr` is new.
- `fetch_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, WAIT, RESP, DISCARD, ERROR.
- IDLE: if `halt`=0, latch `mem_addr`<=`pc`, `mem_req`<=1, clear wait counter, -> WAIT. If `halt`=1, stay. `flush` has no effect in IDLE.
- WAIT: `mem_req`=1, `mem_addr` frozen. `mem_ack`=1 and `flush`=0: `instr`<=`mem_rdata`, `mem_req`<=0, -> RESP. `flush`=1 (with or without ack): if ack, `mem_req`<=0 and -> IDLE, data dropped; if no ack, -> DISCARD. Neither: counter increments; counter reaching TIMEOUT -> ERROR, `mem_req`<=0, `fetch_err`<=1.
- DISCARD: `mem_req` held until `mem_ack`; data dropped, `mem_req`<=0, -> IDLE. Timeout rules as WAIT.
- RESP: lasts one cycle, then -> IDLE. `confirm`=`instr_valid`=1 unless `halt` or `flush` is 1 that cycle; if either is 1, both strobes are 0, `instr` keeps new data but is not announced, and the same PC is re-fetched later.
- ERROR: absorbing until reset; `mem_req`=0, `confirm`=0, `stall`=1.
- `stall` = 0 only in IDLE with `halt`=1; 1 in every other state/condition, so the PC never free-runs.
- `confirm`, `instr_valid`, `stall` are combinational from state, `halt`, `flush`; all other outputs registered.
- Wait counter width ceil(log2(TIMEOUT+1)); never wraps (saturates by leaving WAIT/DISCARD).
- `mem_ack` outside WAIT/DISCARD is ignored.

## Timing
- Reset (reset=0 at edge): state IDLE, `mem_req`=0, `mem_addr`=0, `instr`=0, `fetch_err`=0, counter 0; hence `confirm`=0, `instr_valid`=0, `stall`=1 unless `halt`=1.
- Zero-wait memory (ack in first WAIT cycle): IDLE c0, WAIT c1, RESP c2, IDLE c3 with new PC; 3 cycles per instruction.
- Each extra memory wait cycle adds exactly one cycle.
- PC advances at the end of the RESP cycle (`stall`=1, `confirm`=1); `pc` sampled in the following IDLE is the new address.
- Reset mid-transaction: `mem_req` drops the next cycle; a late `mem_ack` is ignored.
- Timeout: the error is taken on the edge where TIMEOUT consecutive no-ack cycles complete in WAIT/DISCARD.

## Test plan
- Zero-wait: pc=0x00000000 then 0x00000004, ack in each first WAIT cycle with rdata 0x20080005, 0x2009000A -> `mem_addr` 0x0, 0x4; `confirm`/`instr_valid` on c2 and c5; `instr` matches; `stall`=1 throughout.
- Wait states: ack delayed 3 cycles -> `mem_req` high 4 cycles with `mem_addr` stable; single `confirm` 5 cycles after issue.
- Flush: flush during WAIT with no ack, ack 2 cycles later -> DISCARD, no `confirm`/`instr_valid`, `instr` unchanged, next fetch issued from the then-current `pc`.
- Halt in RESP: halt=1 on the RESP cycle -> `confirm`=0, `instr_valid`=0; release halt -> same address re-fetched; IDLE with halt=1 gives `stall`=0, `mem_req`=0.
- Timeout: TIMEOUT=15, ack never arrives -> `fetch_err`=1 and `mem_req`=0 after 15 WAIT cycles; later ack ignored; reset=0 clears `fetch_err`, returns to IDLE.
- Reset mid-WAIT: reset=0 with `mem_req`=1 -> next cycle all registered outputs zero, state IDLE.

Source files
------------

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction-fetch sequencer between PC and instruction memory
module fetch_controller #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              halt,
    input  logic              flush,
    output logic              stall,
    output logic              confirm,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DISCARD,
        S_ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             expire;

    // The current no-ack cycle is the TIMEOUT-th in a row; leaving here keeps the counter from wrapping.
    assign expire = (wait_cnt == CNT_LAST);

    // PC handshake strobes: announce only an undisturbed RESP, and hold the PC unless halted in IDLE.
    always_comb begin
        confirm     = 1'b0;
        instr_valid = 1'b0;
        stall       = 1'b1;
        if (state == S_RESP && !halt && !flush) begin
            confirm     = 1'b1;
            instr_valid = 1'b1;
        end
        if (state == S_IDLE && halt) begin
            stall = 1'b0;
        end
    end

    // Fetch sequencer: issue, wait for ack (or drain a flushed request), deliver, or lock up on timeout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            instr     <= '0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!halt) begin
                        mem_addr <= pc;
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= S_IDLE;
                        end else if (expire) begin
                            mem_req   <= 1'b0;
                            fetch_err <= 1'b1;
                            state     <= S_ERROR;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                            state    <= S_DISCARD;
                        end
                    end else if (mem_ack) begin
                        instr   <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_RESP;
                    end else if (expire) begin
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_IDLE;
                    end else if (expire) begin
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    mem_req <= 1'b0;
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        halt;
    logic        flush;
    logic        stall;
    logic        confirm;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_err;

    int          total = 0;
    int          bad   = 0;
    int          cyc_n = 0;
    logic [31:0] sb[$];

    fetch_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .halt        (halt),
        .flush       (flush),
        .stall       (stall),
        .confirm     (confirm),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    // Advance one clock; the PC model steps on a confirm seen before the edge.
    task automatic cyc();
        logic adv;
        adv = confirm;
        @(posedge clk);
        #1;
        cyc_n++;
        if (adv) pc = pc + 32'd4;
    endtask

    // Full fetch from IDLE with lat wait cycles before ack.
    task automatic fetch(input int lat, input logic [31:0] data);
        logic [31:0] a;
        int          t0;
        a  = pc;
        t0 = cyc_n;
        chk("idle_req", 32'(mem_req), 1'b0);
        cyc();
        for (int i = 0; i < lat; i++) begin
            chk("wait_req", 32'(mem_req), 1'b1);
            chk("wait_addr", mem_addr, a);
            chk("wait_confirm", 32'(confirm), 1'b0);
            cyc();
        end
        chk("ack_addr", mem_addr, a);
        mem_ack   = 1'b1;
        mem_rdata = data;
        sb.push_back(data);
        #1;
        chk("ack_stall", 32'(stall), 1'b1);
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        chk("resp_confirm", 32'(confirm), 1'b1);
        chk("resp_stall", 32'(stall), 1'b1);
        chk("resp_lat", 32'(cyc_n - t0), 32'(lat + 2));
        chk("resp_req", 32'(mem_req), 1'b0);
        cyc();
        chk("next_pc", pc, a + 32'd4);
    endtask

    // Scoreboard consumer: every instr_valid strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (instr_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(instr_valid), 1'b0);
            end else begin
                chk("sb_instr", instr, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        reset = 1'b0; pc = '0; halt = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        cyc();
        cyc();
        // reset state
        chk("rst_req", 32'(mem_req), 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_err", 32'(fetch_err), 1'b0);
        chk("rst_confirm", 32'(confirm), 1'b0);
        chk("rst_valid", 32'(instr_valid), 1'b0);
        chk("rst_stall", 32'(stall), 1'b1);
        halt = 1'b1; #1;
        chk("rst_stall_halt", 32'(stall), 1'b0);
        halt  = 1'b0;
        reset = 1'b1;

        // zero-wait back to back
        fetch(0, 32'h20080005);
        chk("zw_instr0", instr, 32'h20080005);
        fetch(0, 32'h2009000A);
        chk("zw_instr1", instr, 32'h2009000A);

        // three wait states
        fetch(3, 32'h12345678);

        // flush in WAIT without ack, ack two cycles later
        held = instr;
        cyc();
        chk("fl_req", 32'(mem_req), 1'b1);
        flush = 1'b1; #1;
        chk("fl_confirm", 32'(confirm), 1'b0);
        cyc();
        flush = 1'b0;
        chk("disc_req", 32'(mem_req), 1'b1);
        cyc();
        chk("disc_req2", 32'(mem_req), 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        cyc();
        mem_ack = 1'b0;
        chk("disc_drop_req", 32'(mem_req), 1'b0);
        chk("disc_instr", instr, held);
        pc = 32'h00000100;
        fetch(1, 32'hCAFE0001);

        // flush together with ack in WAIT drops data
        held = instr;
        cyc();
        flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        cyc();
        flush = 1'b0; mem_ack = 1'b0;
        chk("flack_req", 32'(mem_req), 1'b0);
        chk("flack_instr", instr, held);
        chk("flack_pc", pc, 32'h00000104);

        // halt during RESP suppresses strobes, same PC re-fetched
        held = pc;
        cyc();
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        cyc();
        mem_ack = 1'b0; halt = 1'b1; #1;
        chk("hr_confirm", 32'(confirm), 1'b0);
        chk("hr_valid", 32'(instr_valid), 1'b0);
        chk("hr_stall", 32'(stall), 1'b1);
        cyc();
        chk("hr_idle_stall", 32'(stall), 1'b0);
        chk("hr_idle_req", 32'(mem_req), 1'b0);
        chk("hr_instr_kept", instr, 32'h55AA55AA);
        cyc();
        chk("hr_pc_held", pc, held);
        halt = 1'b0;
        fetch(0, 32'h66778899);

        // timeout with ack never arriving
        cyc();
        for (int i = 0; i < 15; i++) begin
            chk("to_req", 32'(mem_req), 1'b1);
            chk("to_err_early", 32'(fetch_err), 1'b0);
            cyc();
        end
        chk("to_err", 32'(fetch_err), 1'b1);
        chk("to_req_drop", 32'(mem_req), 1'b0);
        held = instr;
        mem_ack = 1'b1; mem_rdata = 32'h99999999; halt = 1'b1; #1;
        chk("err_stall", 32'(stall), 1'b1);
        chk("err_confirm", 32'(confirm), 1'b0);
        cyc();
        mem_ack = 1'b0; halt = 1'b0;
        chk("err_late_ack", instr, held);
        chk("err_sticky", 32'(fetch_err), 1'b1);
        chk("err_req", 32'(mem_req), 1'b0);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("err_cleared", 32'(fetch_err), 1'b0);
        fetch(0, 32'hA0A0A0A0);

        // reset while a request is outstanding
        pc = 32'h00000040;
        cyc();
        chk("mr_req", 32'(mem_req), 1'b1);
        reset = 1'b0;
        cyc();
        reset = 1'b1; halt = 1'b1;
        chk("mr_req0", 32'(mem_req), 1'b0);
        chk("mr_addr0", mem_addr, 32'h0);
        chk("mr_instr0", instr, 32'h0);
        chk("mr_err0", 32'(fetch_err), 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        cyc();
        mem_ack = 1'b0;
        chk("mr_late_ack_instr", instr, 32'h0);
        chk("mr_late_ack_req", 32'(mem_req), 1'b0);
        halt = 1'b0;
        fetch(2, 32'h0F0F0F0F);

        cyc();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
